// File: rtl/systolic_skew_feeder.sv
// Input stage for systolic_nxn: buffers two NxN operand matrices row by row,
// then replays them as a diagonally skewed wavefront followed by zero drain cycles.
module systolic_skew_feeder #(
  parameter int unsigned N     = 3,
  parameter int unsigned DW    = 8,
  parameter int unsigned DRAIN = N
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] a_row [N],
  input  logic [DW-1:0] b_row [N],
  output logic [DW-1:0] a_out [N],
  output logic [DW-1:0] b_out [N],
  output logic          busy,
  output logic          done
);

  localparam int unsigned SLAST = 2 * N - 2 + DRAIN;
  localparam int unsigned WLAST = 2 * N - 2;
  localparam int unsigned SW    = (SLAST > 0) ? $clog2(SLAST + 1) : 1;
  localparam int unsigned RW    = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [RW-1:0] r, r_nxt;
  logic [SW-1:0] s, s_nxt;
  logic [SW-1:0] pat_s;
  logic          pat_en;
  logic          accept;
  logic          done_nxt;

  logic [DW-1:0] abuf  [N][N];
  logic [DW-1:0] bbuf  [N][N];
  logic [DW-1:0] a_eff [N][N];
  logic [DW-1:0] b_eff [N][N];
  logic [DW-1:0] a_nxt [N];
  logic [DW-1:0] b_nxt [N];

  assign in_ready = (state == ST_LOAD);
  assign busy     = (state == ST_STREAM) || (state == ST_DRAIN);
  assign accept   = in_valid && in_ready;

  // Sequencer: row counter during load, stream counter through wavefront and drain
  always_comb begin
    state_nxt = state;
    r_nxt     = r;
    s_nxt     = s;
    done_nxt  = 1'b0;
    pat_en    = 1'b0;
    pat_s     = '0;
    case (state)
      ST_LOAD: begin
        if (accept) begin
          if (r == RW'(N - 1)) begin
            r_nxt     = '0;
            s_nxt     = '0;
            state_nxt = ST_STREAM;
            pat_en    = 1'b1;
          end else begin
            r_nxt = r + RW'(1);
          end
        end
      end
      ST_STREAM: begin
        if (s == SW'(WLAST)) begin
          if (DRAIN == 0) begin
            state_nxt = ST_DONE;
            s_nxt     = '0;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = ST_DRAIN;
            s_nxt     = s + SW'(1);
          end
        end else begin
          s_nxt  = s + SW'(1);
          pat_en = 1'b1;
          pat_s  = s + SW'(1);
        end
      end
      ST_DRAIN: begin
        if (s == SW'(SLAST)) begin
          state_nxt = ST_DONE;
          s_nxt     = '0;
          done_nxt  = 1'b1;
        end else begin
          s_nxt = s + SW'(1);
        end
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  // The s=0 pattern is launched on the edge that accepts the last row, so it
  // must see that row before it lands in the buffer.
  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      for (int c = 0; c < int'(N); c++) begin
        a_eff[i][c] = (accept && r == RW'(i)) ? a_row[c] : abuf[i][c];
        b_eff[i][c] = (accept && r == RW'(i)) ? b_row[c] : bbuf[i][c];
      end
    end
  end

  // Skew: lane i carries element (s - i) of its row (A) or column (B)
  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      a_nxt[i] = '0;
      b_nxt[i] = '0;
      if (pat_en) begin
        if ((int'(pat_s) - i) >= 0 && (int'(pat_s) - i) < int'(N)) begin
          a_nxt[i] = a_eff[i][RW'(int'(pat_s) - i)];
          b_nxt[i] = b_eff[RW'(int'(pat_s) - i)][i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_LOAD;
      r     <= '0;
      s     <= '0;
      done  <= 1'b0;
      for (int i = 0; i < int'(N); i++) begin
        a_out[i] <= '0;
        b_out[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      r     <= r_nxt;
      s     <= s_nxt;
      done  <= done_nxt;
      for (int i = 0; i < int'(N); i++) begin
        a_out[i] <= a_nxt[i];
        b_out[i] <= b_nxt[i];
      end
    end
  end

  // Operand storage carries no reset; contents are rewritten by every load
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int c = 0; c < int'(N); c++) begin
        abuf[r][c] <= a_row[c];
        bbuf[r][c] <= b_row[c];
      end
    end
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder with a behavioural systolic array
// accumulating the streamed operands to confirm the product at done.
module tb_systolic_skew_feeder;

  localparam int N     = 3;
  localparam int DW    = 8;
  localparam int DRAIN = N;
  localparam int NJ    = N * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready, busy, done;
  logic [DW-1:0] a_row [N];
  logic [DW-1:0] b_row [N];
  logic [DW-1:0] a_out [N];
  logic [DW-1:0] b_out [N];

  systolic_skew_feeder #(.N(N), .DW(DW), .DRAIN(DRAIN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_row(a_row), .b_row(b_row), .a_out(a_out), .b_out(b_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NJ-1:0] a;
    logic [NJ-1:0] b;
    logic          busy;
    logic          done;
  } exp_t;

  exp_t    exp_q[$];
  longint  c_q[$];
  int      done_cyc[$];
  int      checks = 0;
  int      errors = 0;
  int      cyc = 0;
  int      ma [N][N];
  int      mb [N][N];
  longint  acc [N][N];
  int      ar [N][N];
  int      br [N][N];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NJ-1:0] pack(input logic [DW-1:0] v [N]);
    logic [NJ-1:0] p;
    for (int i = 0; i < N; i++) p[i*DW +: DW] = v[i];
    return p;
  endfunction

  // Expected skewed beats, the done beat and the product for the job just accepted
  task automatic push_job();
    exp_t e;
    for (int s = 0; s <= 2*N-2+DRAIN; s++) begin
      e = '0;
      e.busy = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (s <= 2*N-2 && s-i >= 0 && s-i < N) begin
          e.a[i*DW +: DW] = DW'(ma[i][s-i]);
          e.b[i*DW +: DW] = DW'(mb[s-i][i]);
        end
      end
      exp_q.push_back(e);
    end
    e = '0;
    e.done = 1'b1;
    exp_q.push_back(e);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        longint sum = 0;
        for (int k = 0; k < N; k++) sum += longint'(ma[i][k]) * longint'(mb[k][j]);
        c_q.push_back(sum);
      end
  endtask

  task automatic load_job(input int gap, input bit garbage);
    for (int r = 0; r < N; r++) begin
      int guard = 0;
      @(negedge clk);
      in_valid = 1'b0;
      for (int g = 0; g < gap; g++) @(negedge clk);
      in_valid = 1'b1;
      for (int c = 0; c < N; c++) begin
        a_row[c] = DW'(ma[r][c]);
        b_row[c] = DW'(mb[r][c]);
      end
      while (!in_ready && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 100) check_val("ready_timeout", 64'(guard), 64'(0));
      @(posedge clk);
      if (r == N-1) push_job();
    end
    @(negedge clk);
    in_valid = garbage;
    for (int c = 0; c < N; c++) begin
      a_row[c] = DW'($urandom);
      b_row[c] = DW'($urandom);
    end
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    if (guard >= 200) check_val("idle_timeout", 64'(exp_q.size()), 64'(0));
    @(negedge clk);
  endtask

  always @(posedge clk) cyc++;

  // Monitor: behavioural array step, then compare against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_ready) begin
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) begin
            acc[i][j] = 0; ar[i][j] = 0; br[i][j] = 0;
          end
      end else begin
        for (int i = N-1; i >= 0; i--)
          for (int j = N-1; j >= 0; j--) begin
            int al, bt;
            al = (j == 0) ? int'(a_out[i]) : ar[i][j-1];
            bt = (i == 0) ? int'(b_out[j]) : br[i-1][j];
            acc[i][j] += longint'(al) * longint'(bt);
            ar[i][j] = al;
            br[i][j] = bt;
          end
      end
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check_val("a_out", 64'(pack(a_out)), 64'(e.a));
        check_val("b_out", 64'(pack(b_out)), 64'(e.b));
        check_val("busy", 64'(busy), 64'(e.busy));
        check_val("done", 64'(done), 64'(e.done));
        check_val("in_ready_low", 64'(in_ready), 64'(0));
        if (e.done) begin
          done_cyc.push_back(cyc);
          for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
              longint ce;
              ce = (c_q.size() != 0) ? c_q.pop_front() : -1;
              check_val($sformatf("c[%0d][%0d]", i, j), 64'(acc[i][j]), 64'(ce));
            end
        end
      end else begin
        check_val("idle_ready", 64'(in_ready), 64'(1));
        check_val("idle_busy_done", 64'({busy, done}), 64'(0));
        check_val("idle_outs", 64'({pack(a_out), pack(b_out)}), 64'(0));
      end
    end
  end

  task automatic set_mats(input int kind);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        mb[i][j] = (kind == 2) ? 255 : i*N + j + 1;
        case (kind)
          1:       ma[i][j] = (i == j) ? 1 : 0;
          2:       ma[i][j] = 255;
          default: ma[i][j] = i*N + j + 1;
        endcase
      end
  endtask

  initial begin
    for (int c = 0; c < N; c++) begin
      a_row[c] = '0;
      b_row[c] = '0;
    end
    #2;
    check_val("rst_outs", 64'({pack(a_out), pack(b_out)}), 64'(0));
    check_val("rst_ready", 64'(in_ready), 64'(1));
    check_val("rst_busy_done", 64'({busy, done}), 64'(0));
    #10 rst_n = 1'b1;

    // Basic skew, back-to-back rows
    set_mats(0);
    load_job(0, 1'b0);
    wait_idle();

    // Idle gaps between rows, garbage held valid during stream
    load_job(2, 1'b1);
    wait_idle();

    // Asynchronous reset at stream cycle 3
    load_job(0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst_outs", 64'({pack(a_out), pack(b_out)}), 64'(0));
    check_val("mid_rst_ready", 64'(in_ready), 64'(1));
    check_val("mid_rst_busy_done", 64'({busy, done}), 64'(0));
    exp_q.delete();
    c_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    set_mats(1);
    load_job(1, 1'b0);
    wait_idle();

    // Back-to-back jobs: all-ones boundary then the original pair
    set_mats(2);
    load_job(0, 1'b0);
    set_mats(0);
    load_job(0, 1'b0);
    wait_idle();
    if (done_cyc.size() >= 2)
      check_val("done_gap", 64'(done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2]),
                64'(3 + 8 + 1));
    else
      check_val("done_count", 64'(done_cyc.size()), 64'(2));

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Upstream input stage for `systolic_nxn`. It accepts two N×N operand matrices row by row over a valid/ready handshake and buffers them internally. It then drives the array's `A_in[N]`/`B_in[N]` ports with the diagonally skewed wavefront, followed by zero flush cycles. It pulses `done` when the array's `C` outputs hold the finished product, so the multiply sequence no longer lives in testbench code.

## Interface
- `N`, 3, array dimension; must match `systolic_nxn.N`.
- `DW`, 8, operand width; must match `systolic_nxn.DW`.
- `DRAIN`, N, zero cycles driven after the data wavefront before `done`.
- `clk`  in  1  sole clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  `a_row`/`b_row` carry the next row.
- `in_ready`  out  1  feeder accepts a row this cycle.
- `a_row[N]`  in  DW each  row r of A: `a_row[c]` = A[r][c].
- `b_row[N]`  in  DW each  row r of B: `b_row[c]` = B[r][c].
- `a_out[N]`  out  DW each  registered; connects to `systolic_nxn.A_in`.
- `b_out[N]`  out  DW each  registered; connects to `systolic_nxn.B_in`.
- `busy`  out  1  high in STREAM and DRAIN.
- `done`  out  1  one-cycle pulse; product is complete in the array.

## Operation
- Storage: two N×N×DW register buffers, `abuf` and `bbuf`. Row counter `r` runs 0..N-1. Stream counter `s` runs 0..2N-2+DRAIN.
- State machine:
  - LOAD (reset state): `in_ready`=1, `busy`=0.
  - STREAM: s = 0..2N-2.
  - DRAIN: s = 2N-1..2N-2+DRAIN.
  - DONE: one cycle, then LOAD.
- LOAD behaviour:
  - Accept on `in_valid && in_ready` at a rising edge: `abuf[r]` ← `a_row`, `bbuf[r]` ← `b_row`, r++.
  - Idle cycles (`in_valid`=0) between beats are allowed; they leave r and the buffers unchanged.
  - On accepting row r = N-1: r ← 0 and state → STREAM. `a_out`/`b_out` are loaded with the s=0 pattern at that same edge, computed from the incoming row combined with the buffered rows.
- Skew rule for stream cycle s:
  - `a_out[i]` = A[i][s-i] when 0 ≤ s-i < N, else 0.
  - `b_out[j]` = B[s-j][j] when 0 ≤ s-j < N, else 0.
- DRAIN: all `a_out`/`b_out` = 0.
- DONE: `done`=1, outputs 0, `in_ready`=0.
- Outside LOAD, `in_ready`=0 and `in_valid` is ignored; no row is lost or overwritten.
- No arithmetic beyond counters. Counter width is $clog2(2N-1+DRAIN). Data passes through unmodified at DW bits.

## Timing
- Reset values: `a_out`=`b_out`=0, `in_ready`=1, `busy`=0, `done`=0, state LOAD, r=s=0. Buffer contents are don't-care.
- Reset assertion mid-operation clears state and outputs immediately, with no clock needed. Any partial load or stream is abandoned. The next load starts at row 0.
- `in_ready` and `busy` are decoded from state; `done` is registered.
- Cycle numbering: cycle 0 of STREAM is the cycle immediately after the edge that accepted row N-1.
  - STREAM occupies cycles 0..2N-2.
  - DRAIN occupies cycles 2N-1..2N-2+DRAIN.
  - `done` is high in cycle 2N-1+DRAIN.
  - `in_ready` returns high in cycle 2N+DRAIN.
- With default DRAIN=N, `done` is at cycle 3N-1. This covers the array's last partial product reaching PE[N-1][N-1] at cycle 3N-3 and being registered by cycle 3N-2.
- Minimum period per matrix pair: N load cycles + 2N+DRAIN cycles.

## Test plan
- Skew pattern, N=3, A=B={{1,2,3},{4,5,6},{7,8,9}}, rows loaded back-to-back. Required `a_out`/`b_out` per stream cycle:
  - s=0: {1,0,0} / {1,0,0}
  - s=2: {3,5,7} / {7,5,3}
  - s=4: {0,0,9} / {0,0,9}
  - s=5..7: all zeros
  - `done` high at s=8 only.
- Integration: feeder driving `systolic_nxn`, same matrices. At the `done` cycle C = {{30,36,42},{66,81,96},{102,126,150}}.
- Back-pressure and idles: gaps in `in_valid` between rows; `in_valid` held high during STREAM with garbage data. Buffered data and the result are unchanged; `in_ready` stays 0 from stream cycle 0 through the `done` cycle.
- Reset mid-stream: drop `rst_n` at stream cycle 3. All outputs read 0 while `rst_n` is low, with no clock edge required. After release `in_ready`=1, and a fresh load of A = identity, B as above yields C = B.
- Back-to-back jobs: a second load begins the cycle `in_ready` rises. The second `done` arrives exactly 3+8+1 cycles after the first.
- Boundary values: A = B = all 8'hFF. `a_out`/`b_out` carry 255 unaltered; the array result is C[i][j] = 195075 in every position.
